idp_enc_arbiter: RTL and testbench

//  Shares one IDP_encoder_07-class FNS crosstalk-avoidance encoder between NREQ requesters.
//  - Round-robin arbitration over valid/ready request ports.
//  - Range-checks each operand against the encoder codebook.
//  - Drives the encoder input and re-times its registered codeword into an output FIFO,

---
 rtl/idp_enc_arbiter_if.sv | 36 +++
 rtl/idp_enc_arbiter.sv | 164 ++++++++++++++++
 tb/tb_idp_enc_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/idp_enc_arbiter_if.sv
// Bundles the requester, encoder and output-side signals of idp_enc_arbiter.
// Ports (by group):
//   requesters : req_valid, req_data (operand i at [i*DW +: DW]), req_ready
//   encoder    : enc_datain (to encoder), enc_codeout (from encoder)
//   output     : out_valid, out_code, out_id, out_ready
//   errors     : err_valid, err_id
// slave  = the arbiter itself; master = everything around it.
interface idp_enc_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 5,
  parameter int unsigned CW   = 7
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [DW-1:0]      enc_datain;
  logic [CW-1:0]      enc_codeout;
  logic               out_valid;
  logic [CW-1:0]      out_code;
  logic [IDW-1:0]     out_id;
  logic               out_ready;
  logic               err_valid;
  logic [IDW-1:0]     err_id;

  modport slave (
    input  req_valid, req_data, enc_codeout, out_ready,
    output req_ready, enc_datain, out_valid, out_code, out_id, err_valid, err_id
  );

  modport master (
    output req_valid, req_data, enc_codeout, out_ready,
    input  req_ready, enc_datain, out_valid, out_code, out_id, err_valid, err_id
  );
endinterface

// File: rtl/idp_enc_arbiter.sv
// Shares one registered FNS crosstalk-avoidance encoder between NREQ requesters.
// Round-robin arbitration, codebook range check, two-stage id pipe aligned with
// the encoder's register, and a first-word fall-through output FIFO guarded by
// a credit so backpressure never drops a codeword.
// Ports:
//   clock : system clock, all state on posedge
//   reset : asynchronous, active-high; clears pipe, FIFO and pointer
//   bus   : idp_enc_arbiter_if.slave (requesters, encoder, output, error pulse)
module idp_enc_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned DW         = 5,
  parameter int unsigned CW         = 7,
  parameter int unsigned CB_SIZE    = 26,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  idp_enc_arbiter_if.slave  bus
);

  localparam int unsigned IDW  = $clog2(NREQ);
  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = PW + 2;
  localparam logic [DW:0]   CB_LIMIT  = (DW+1)'(CB_SIZE);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);
  localparam logic [PW:0]   FULL_CNT  = (PW+1)'(FIFO_DEPTH);
  localparam logic [CNTW-1:0] DEPTH_W = CNTW'(FIFO_DEPTH);

  typedef struct packed {
    logic [CW-1:0]  code;
    logic [IDW-1:0] id;
  } entry_t;

  // Arbitration / issue state
  logic [IDW-1:0]  rr_ptr;
  logic [DW-1:0]   enc_q;
  logic            s0_valid;
  logic [IDW-1:0]  s0_id;
  logic            s1_valid;
  logic [IDW-1:0]  s1_id;
  logic            err_valid_q;
  logic [IDW-1:0]  err_id_q;

  // FIFO state
  entry_t          mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     fifo_count;

  // Combinational decode
  logic [NREQ-1:0] grant_c;
  logic [NREQ-1:0] ready_c;
  logic [IDW-1:0]  win_c;
  logic            found_c;
  logic [DW-1:0]   operand_c;
  logic [1:0]      pipe_count_c;
  logic            credit_c;
  logic            xfer_c;
  logic            legal_c;
  logic            push_c;
  logic            pop_c;
  entry_t          head_c;

  // Credit covers both FIFO entries and codewords still in the pipe, so every
  // granted operand already owns a FIFO slot.
  assign pipe_count_c = {1'b0, s0_valid} + {1'b0, s1_valid};
  assign credit_c     = (CNTW'(fifo_count) + CNTW'(pipe_count_c)) < DEPTH_W;

  // Round-robin scan starting at rr_ptr, wrapping past NREQ-1.
  always_comb begin
    int unsigned pos;
    grant_c = '0;
    win_c   = '0;
    found_c = 1'b0;
    pos     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = 32'(rr_ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!found_c && bus.req_valid[IDW'(pos)]) begin
        found_c                = 1'b1;
        win_c                  = IDW'(pos);
        grant_c[IDW'(pos)]     = 1'b1;
      end
    end
  end

  // Ready is held low during reset even though the scan itself is combinational.
  assign ready_c       = (reset || !credit_c) ? '0 : grant_c;
  assign bus.req_ready = ready_c;
  assign xfer_c        = |(bus.req_valid & ready_c);

  // Operand of the granted requester.
  always_comb begin
    operand_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_c[i]) operand_c = bus.req_data[i*DW +: DW];
    end
  end

  assign legal_c = {1'b0, operand_c} < CB_LIMIT;

  // Issue: drive encoder, track id alongside the encoder's own register stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr      <= '0;
      enc_q       <= '0;
      s0_valid    <= 1'b0;
      s0_id       <= '0;
      s1_valid    <= 1'b0;
      s1_id       <= '0;
      err_valid_q <= 1'b0;
      err_id_q    <= '0;
    end else begin
      if (xfer_c) rr_ptr <= (win_c == LAST_ID) ? '0 : win_c + IDW'(1);
      // Idle and rejected cycles park the encoder on operand 0, a legal quiet codeword.
      enc_q       <= (xfer_c && legal_c) ? operand_c : '0;
      s0_valid    <= xfer_c && legal_c;
      s0_id       <= win_c;
      s1_valid    <= s0_valid;
      s1_id       <= s0_id;
      err_valid_q <= xfer_c && !legal_c;
      if (xfer_c && !legal_c) err_id_q <= win_c;
    end
  end

  assign bus.enc_datain = enc_q;
  assign bus.err_valid  = err_valid_q;
  assign bus.err_id     = err_id_q;

  // Stage1 lines up with the encoder output register, so its codeout is captured here.
  assign push_c = s1_valid;
  assign pop_c  = (fifo_count != '0) && bus.out_ready;

  // Output FIFO, first-word fall-through.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= '{code: bus.enc_codeout, id: s1_id};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PW'(1);
      case ({push_c, pop_c})
        2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign head_c       = mem[rd_ptr];
  assign bus.out_valid = (fifo_count != '0);
  assign bus.out_code  = head_c.code;
  assign bus.out_id    = head_c.id;

  // Credit should make a push into a full FIFO without a pop unreachable.
  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(push_c && !pop_c && fifo_count == FULL_CNT));

endmodule

// File: tb/tb_idp_enc_arbiter.sv
// Directed bench for idp_enc_arbiter with a registered FNS (Zeckendorf) encoder model.
module tb_idp_enc_arbiter;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  idp_enc_arbiter_if #(.NREQ(4), .DW(5), .CW(7)) bus ();

  idp_enc_arbiter #(
    .NREQ(4), .DW(5), .CW(7), .CB_SIZE(26), .FIFO_DEPTH(4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Encoder model: registers datain every clock, greedy Fibonacci weights 21..1.
  function automatic logic [6:0] fns(input logic [4:0] v);
    int rem;
    int w [7];
    logic [6:0] c;
    w   = '{1, 2, 3, 5, 8, 13, 21};
    rem = int'(v);
    c   = '0;
    for (int b = 6; b >= 0; b--) begin
      if (rem >= w[b]) begin
        c[b] = 1'b1;
        rem  = rem - w[b];
      end
    end
    return c;
  endfunction

  logic [4:0] enc_q;
  always @(posedge clock) enc_q <= bus.enc_datain;
  assign bus.enc_codeout = fns(enc_q);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  logic [6:0] code_tab [4];
  logic [3:0] gid_oh;
  int         gid;

  initial begin
    vectors     = 0;
    miscompares = 0;
    code_tab    = '{7'h00, 7'h01, 7'h02, 7'h04};
    enc_q       = '0;
    reset         = 1'b1;
    bus.req_valid = 4'h0;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    #3;
    // Reset values, including ready held low while requests are pending.
    bus.req_valid = 4'hF;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_enc_datain", 32'(bus.enc_datain), 32'h0);
    check("rst_err_valid", 32'(bus.err_valid), 32'h0);
    check("rst_out_code", 32'(bus.out_code), 32'h0);
    check("rst_out_id", 32'(bus.out_id), 32'h0);
    bus.req_valid = 4'h0;
    tick();
    reset = 1'b0;
    tick();

    // Single requester 0, operand 5 -> 0001000 two cycles after accept.
    bus.req_data  = {5'd0, 5'd0, 5'd0, 5'd5};
    bus.req_valid = 4'b0001;
    #1;
    check("single_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 4'b0000;
    check("single_enc_datain", 32'(bus.enc_datain), 32'd5);
    check("single_ov_t1", 32'(bus.out_valid), 32'h0);
    tick();
    check("single_ov_t2", 32'(bus.out_valid), 32'h0);
    tick();
    check("single_ov", 32'(bus.out_valid), 32'h1);
    check("single_code", 32'(bus.out_code), 32'b0001000);
    check("single_id", 32'(bus.out_id), 32'h0);
    tick();
    check("single_drained", 32'(bus.out_valid), 32'h0);

    // All four streaming, rr_ptr=1: grants 1,2,3,0,1,2,3,0 then outputs in that order.
    bus.req_data = {5'd3, 5'd2, 5'd1, 5'd0};
    for (int j = 0; j < 11; j++) begin
      bus.req_valid = (j < 8) ? 4'hF : 4'h0;
      #1;
      if (j < 8) begin
        gid    = (1 + j) % 4;
        gid_oh = 4'b0001 << gid;
        check($sformatf("stream_grant_%0d", j), 32'(bus.req_ready), 32'(gid_oh));
      end
      if (j >= 3) begin
        gid = (1 + j - 3) % 4;
        check($sformatf("stream_ov_%0d", j), 32'(bus.out_valid), 32'h1);
        check($sformatf("stream_id_%0d", j), 32'(bus.out_id), 32'(gid));
        check($sformatf("stream_code_%0d", j), 32'(bus.out_code), 32'(code_tab[gid]));
      end
      tick();
    end
    check("stream_drained", 32'(bus.out_valid), 32'h0);

    // Reject: requester 2, operand 26. rr_ptr=1 -> grant 2, then pointer at 3.
    bus.req_data  = {5'd0, 5'd26, 5'd0, 5'd0};
    bus.req_valid = 4'b0100;
    #1;
    check("rej_ready", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = 4'b0000;
    check("rej_err_valid", 32'(bus.err_valid), 32'h1);
    check("rej_err_id", 32'(bus.err_id), 32'h2);
    check("rej_enc_datain", 32'(bus.enc_datain), 32'h0);
    tick();
    check("rej_err_pulse_end", 32'(bus.err_valid), 32'h0);
    check("rej_no_out_1", 32'(bus.out_valid), 32'h0);
    tick();
    check("rej_no_out_2", 32'(bus.out_valid), 32'h0);
    bus.req_valid = 4'hF;
    #1;
    check("rej_rr_at_3", 32'(bus.req_ready), 32'h8);
    bus.req_valid = 4'h0;
    tick();

    // Backpressure: requester 1 streams operand 25 (1000101) with out_ready low.
    bus.out_ready = 1'b0;
    bus.req_data  = {5'd0, 5'd0, 5'd25, 5'd0};
    bus.req_valid = 4'b0010;
    for (int j = 0; j < 7; j++) begin
      #1;
      check($sformatf("bp_ready_%0d", j), 32'(bus.req_ready), (j < 4) ? 32'h2 : 32'h0);
      tick();
    end
    check("bp_full_ov", 32'(bus.out_valid), 32'h1);
    check("bp_full_code", 32'(bus.out_code), 32'b1000101);
    check("bp_full_id", 32'(bus.out_id), 32'h1);
    bus.out_ready = 1'b1;
    #1;
    check("bp_pop_cycle_ready", 32'(bus.req_ready), 32'h0);
    tick();
    bus.out_ready = 1'b0;
    #1;
    check("bp_regrant", 32'(bus.req_ready), 32'h2);
    tick();
    #1;
    check("bp_refull_1", 32'(bus.req_ready), 32'h0);
    tick();
    tick();
    check("bp_refull_2", 32'(bus.req_ready), 32'h0);
    bus.req_valid = 4'b0000;
    bus.out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      check($sformatf("bp_drain_ov_%0d", j), 32'(bus.out_valid), 32'h1);
      check($sformatf("bp_drain_code_%0d", j), 32'(bus.out_code), 32'b1000101);
      tick();
    end
    check("bp_drain_empty", 32'(bus.out_valid), 32'h0);

    // Reset mid-operation: rr_ptr=2, grants 2,3,0,1 with out_ready low.
    bus.out_ready = 1'b0;
    bus.req_data  = {5'd3, 5'd2, 5'd1, 5'd0};
    bus.req_valid = 4'hF;
    #1;
    check("mid_first_grant", 32'(bus.req_ready), 32'h4);
    for (int j = 0; j < 4; j++) tick();
    check("mid_busy_ov", 32'(bus.out_valid), 32'h1);
    check("mid_busy_id", 32'(bus.out_id), 32'h2);
    check("mid_busy_code", 32'(bus.out_code), 32'b0000010);
    reset = 1'b1;
    #1;
    check("mid_rst_ov", 32'(bus.out_valid), 32'h0);
    check("mid_rst_ready", 32'(bus.req_ready), 32'h0);
    check("mid_rst_code", 32'(bus.out_code), 32'h0);
    check("mid_rst_id", 32'(bus.out_id), 32'h0);
    check("mid_rst_enc", 32'(bus.enc_datain), 32'h0);
    check("mid_rst_err_id", 32'(bus.err_id), 32'h0);
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("post_rst_grant", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = 4'b0000;
    tick();
    check("post_rst_no_stale", 32'(bus.out_valid), 32'h0);
    tick();
    check("post_rst_ov", 32'(bus.out_valid), 32'h1);
    check("post_rst_id", 32'(bus.out_id), 32'h0);
    check("post_rst_code", 32'(bus.out_code), 32'h0);
    tick();
    check("post_rst_empty", 32'(bus.out_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
